// File: rtl/repetition_compactor_pkg.sv
// repetition_compactor_pkg
//   Shared definitions for the repetition compactor: iteration FSM state
//   encoding, derived field widths and the bit offsets of each field inside
//   the packed result word (LSB first: uniq values, idx map, zero mask, count).
package repetition_compactor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    function automatic int idx_w(input int group_size);
        return (group_size <= 1) ? 1 : $clog2(group_size);
    endfunction

    function automatic int cnt_w(input int group_size);
        return $clog2(group_size + 1);
    endfunction

    function automatic int input_w(input int group_size, input int data_width);
        return group_size * data_width;
    endfunction

    function automatic int idx_off(input int group_size, input int data_width);
        return input_w(group_size, data_width);
    endfunction

    function automatic int zmask_off(input int group_size, input int data_width);
        return idx_off(group_size, data_width) + group_size * idx_w(group_size);
    endfunction

    function automatic int cnt_off(input int group_size, input int data_width);
        return zmask_off(group_size, data_width) + group_size;
    endfunction

    function automatic int output_w(input int group_size, input int data_width);
        return cnt_off(group_size, data_width) + cnt_w(group_size);
    endfunction

endpackage

// File: rtl/repetition_compactor_if.sv
// repetition_compactor_if
//   Stream bundle around the compactor: the input beat side (data_in,
//   valid_in, avail_out) and the result side (data_out, valid_out, avail_in).
//   master : environment (upstream writer + downstream consumer)
//   slave  : the compactor itself
interface repetition_compactor_if #(
    parameter int GROUP_SIZE = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int INPUT_WIDTH  = repetition_compactor_pkg::input_w(GROUP_SIZE, DATA_WIDTH);
    localparam int OUTPUT_WIDTH = repetition_compactor_pkg::output_w(GROUP_SIZE, DATA_WIDTH);

    logic [INPUT_WIDTH-1:0]  data_in;
    logic                    valid_in;
    logic                    avail_out;
    logic [OUTPUT_WIDTH-1:0] data_out;
    logic                    valid_out;
    logic                    avail_in;

    modport master (
        output data_in,
        output valid_in,
        input  avail_out,
        input  data_out,
        input  valid_out,
        output avail_in
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output avail_out,
        output data_out,
        output valid_out,
        input  avail_in
    );
endinterface

// File: rtl/repetition_compactor_fifo.sv
// repetition_compactor_fifo
//   First-word-fall-through beat buffer. A beat written in cycle t is at the
//   head (rd_data, empty=0) in cycle t+1. Writes while full and reads while
//   empty are ignored.
//   Ports: clk, rst (sync, active-high), wr_en/wr_data, rd_en/rd_data,
//          empty, full, almost_full (exactly one free slot).
module repetition_compactor_fifo #(
    parameter int WIDTH         = 32,
    parameter int NUM_SLOTS     = 4,
    parameter int LOG_NUM_SLOTS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic             almost_full
);
    logic [WIDTH-1:0]         mem [NUM_SLOTS];
    logic [LOG_NUM_SLOTS-1:0] wr_ptr;
    logic [LOG_NUM_SLOTS-1:0] rd_ptr;
    logic [LOG_NUM_SLOTS:0]   count;
    logic                     do_wr;
    logic                     do_rd;

    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    assign empty       = (count == '0);
    assign full        = (count == (LOG_NUM_SLOTS+1)'(NUM_SLOTS));
    assign almost_full = (count == (LOG_NUM_SLOTS+1)'(NUM_SLOTS - 1));
    assign rd_data     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + LOG_NUM_SLOTS'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + LOG_NUM_SLOTS'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (LOG_NUM_SLOTS+1)'(1);
                2'b01:   count <= count - (LOG_NUM_SLOTS+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/repetition_compactor.sv
// repetition_compactor
//   Per beat of GROUP_SIZE activations, emits the compacted unique-value list,
//   an index map of every element into that list, a zero mask and the unique
//   count, so the downstream multiplier array computes only the unique
//   products. Beats are consumed under an iteration FSM (num_iters x
//   num_reads_per_iter beats) and the result is held in an output register
//   with backpressure.
//   Ports: clk, rst (sync, active-high); configure pulse with num_iters,
//          num_reads_per_iter, zero_skip; bus (input beat side and result
//          side); done pulse; unique_total (saturating sum of unique counts).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | not configured / sequence finished, no beats consumed
//   ST_RUN  | consuming beats, counting reads and iterations down
//   ST_FIN  | last beat consumed; waits for output to drain, pulses done
module repetition_compactor
    import repetition_compactor_pkg::*;
#(
    parameter int GROUP_SIZE             = 4,
    parameter int DATA_WIDTH             = 8,
    parameter int FIFO_DEPTH             = 4,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16,
    parameter int STAT_WIDTH             = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              configure,
    input  logic [LOG_MAX_ITERS-1:0]          num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
    input  logic                              zero_skip,
    repetition_compactor_if.slave             bus,
    output logic                              done,
    output logic [STAT_WIDTH-1:0]             unique_total
);
    localparam int IDX_W        = idx_w(GROUP_SIZE);
    localparam int CNT_W        = cnt_w(GROUP_SIZE);
    localparam int INPUT_WIDTH  = input_w(GROUP_SIZE, DATA_WIDTH);
    localparam int OUTPUT_WIDTH = output_w(GROUP_SIZE, DATA_WIDTH);
    localparam int IDX_OFF      = idx_off(GROUP_SIZE, DATA_WIDTH);
    localparam int ZMASK_OFF    = zmask_off(GROUP_SIZE, DATA_WIDTH);
    localparam int CNT_OFF      = cnt_off(GROUP_SIZE, DATA_WIDTH);

    logic                              empty;
    logic                              full;
    logic                              almost_full;
    logic [INPUT_WIDTH-1:0]            head;
    logic                              fire;

    state_t                            state;
    logic [LOG_MAX_ITERS-1:0]          iters_left;
    logic [LOG_MAX_READS_PER_ITER-1:0] reads_left;
    logic [LOG_MAX_READS_PER_ITER-1:0] reads_reload;
    logic                              zero_skip_r;

    logic                              valid_out_r;
    logic [OUTPUT_WIDTH-1:0]           data_out_r;

    logic [DATA_WIDTH-1:0]             elem [GROUP_SIZE];
    logic [GROUP_SIZE-1:0]             is_zero;
    logic [GROUP_SIZE-1:0]             is_first;
    logic [CNT_W-1:0]                  pos  [GROUP_SIZE];
    logic [DATA_WIDTH-1:0]             uniq [GROUP_SIZE];
    logic [IDX_W-1:0]                  idx  [GROUP_SIZE];
    logic [CNT_W-1:0]                  uniq_cnt;
    logic [OUTPUT_WIDTH-1:0]           result;
    logic [STAT_WIDTH:0]               total_sum;

    repetition_compactor_fifo #(
        .WIDTH         (INPUT_WIDTH),
        .NUM_SLOTS     (FIFO_DEPTH),
        .LOG_NUM_SLOTS ($clog2(FIFO_DEPTH))
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (bus.valid_in),
        .wr_data     (bus.data_in),
        .rd_en       (fire),
        .rd_data     (head),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full)
    );

    // Deasserting one slot early lets upstream land one more beat after
    // avail_out falls without overflowing.
    assign bus.avail_out = ~full & ~almost_full;
    assign fire          = (state == ST_RUN) & ~empty & (bus.avail_in | ~valid_out_r);
    assign bus.data_out  = data_out_r;
    assign bus.valid_out = valid_out_r;

    for (genvar j = 0; j < GROUP_SIZE; j++) begin : g_elem
        assign elem[j]    = head[j*DATA_WIDTH +: DATA_WIDTH];
        assign is_zero[j] = (elem[j] == '0);
    end

    // Element j is a first occurrence if no earlier element matches it; its
    // slot in the unique list is the running count of earlier firsts. A
    // repeat takes the slot of the earliest match, which is always a first
    // occurrence (zeros are never first in zero-skip mode and map to 0).
    always_comb begin
        logic found;
        found    = 1'b0;
        uniq_cnt = '0;
        is_first = '0;
        result   = '0;
        for (int j = 0; j < GROUP_SIZE; j++) begin
            pos[j]  = '0;
            uniq[j] = '0;
            idx[j]  = '0;
        end
        for (int j = 0; j < GROUP_SIZE; j++) begin
            pos[j]      = uniq_cnt;
            is_first[j] = ~(zero_skip_r & is_zero[j]);
            for (int k = 0; k < j; k++) begin
                if (elem[k] == elem[j]) begin
                    is_first[j] = 1'b0;
                end
            end
            if (is_first[j]) begin
                idx[j] = pos[j][IDX_W-1:0];
            end else if (!(zero_skip_r & is_zero[j])) begin
                found = 1'b0;
                for (int k = 0; k < j; k++) begin
                    if (!found && elem[k] == elem[j]) begin
                        idx[j] = pos[k][IDX_W-1:0];
                        found  = 1'b1;
                    end
                end
            end
            uniq_cnt = uniq_cnt + CNT_W'(is_first[j]);
        end
        for (int j = 0; j < GROUP_SIZE; j++) begin
            for (int p = 0; p < GROUP_SIZE; p++) begin
                if (is_first[j] && pos[j] == CNT_W'(p)) begin
                    uniq[p] = elem[j];
                end
            end
        end
        for (int j = 0; j < GROUP_SIZE; j++) begin
            result[j*DATA_WIDTH +: DATA_WIDTH] = uniq[j];
            result[IDX_OFF + j*IDX_W +: IDX_W] = idx[j];
            result[ZMASK_OFF + j]              = is_zero[j];
        end
        result[CNT_OFF +: CNT_W] = uniq_cnt;
    end

    assign total_sum = {1'b0, unique_total} + (STAT_WIDTH+1)'(uniq_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out_r <= 1'b0;
            data_out_r  <= '0;
        end else if (fire) begin
            valid_out_r <= 1'b1;
            data_out_r  <= result;
        end else if (bus.avail_in) begin
            valid_out_r <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            iters_left   <= '0;
            reads_left   <= '0;
            reads_reload <= '0;
            zero_skip_r  <= 1'b0;
            done         <= 1'b0;
            unique_total <= '0;
        end else begin
            done <= 1'b0;
            if (fire) begin
                unique_total <= total_sum[STAT_WIDTH] ? '1 : total_sum[STAT_WIDTH-1:0];
            end
            // A new configuration overrides any count-down from a same-cycle
            // fire; the fired beat itself still leaves the FIFO.
            if (configure) begin
                iters_left   <= num_iters;
                reads_left   <= num_reads_per_iter;
                reads_reload <= num_reads_per_iter;
                zero_skip_r  <= zero_skip;
                unique_total <= '0;
                if (num_iters != '0 && num_reads_per_iter != '0) begin
                    state <= ST_RUN;
                end else begin
                    state <= ST_FIN;
                end
            end else begin
                case (state)
                    ST_RUN: begin
                        if (fire) begin
                            if (reads_left == LOG_MAX_READS_PER_ITER'(1)) begin
                                if (iters_left == LOG_MAX_ITERS'(1)) begin
                                    state <= ST_FIN;
                                end else begin
                                    iters_left <= iters_left - LOG_MAX_ITERS'(1);
                                    reads_left <= reads_reload;
                                end
                            end else begin
                                reads_left <= reads_left - LOG_MAX_READS_PER_ITER'(1);
                            end
                        end
                    end
                    ST_FIN: begin
                        if (!valid_out_r || bus.avail_in) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/repetition_compactor.md
Name: repetition_compactor

Overview:
Successor to the group repetition detector. Takes GROUP_SIZE activations per beat and finds their unique values. For each beat it emits a compacted unique-value list, a per-element index map into that list, a zero mask and the unique count. It sits between the activation FIFO path and the reuse-aware multiplier array, so downstream computes only UNIQUE_CNT products per group.

New relative to the predecessor:
- parametrised input buffer depth;
- optional zero-skip mode;
- registered output stage with backpressure;
- done pulse;
- unique-count statistics counter.

Parameters:
- GROUP_SIZE, 4, elements per group (>=2).
- DATA_WIDTH, 8, bits per element.
- FIFO_DEPTH, 4, input buffer slots (power of two, >=4).
- LOG_MAX_ITERS, 16, width of iteration counter.
- LOG_MAX_READS_PER_ITER, 16, width of reads-per-iteration counter.
- STAT_WIDTH, 32, width of unique-value statistics counter.
- Derived localparams:
  - IDX_W = $clog2(GROUP_SIZE)
  - CNT_W = $clog2(GROUP_SIZE+1)
  - INPUT_WIDTH = GROUP_SIZE*DATA_WIDTH
  - OUTPUT_WIDTH = INPUT_WIDTH + GROUP_SIZE*IDX_W + GROUP_SIZE + CNT_W

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset; synchronous, active-high.
- configure  in  1  one-cycle pulse; latches the configuration inputs below.
- num_iters  in  LOG_MAX_ITERS  number of iterations.
- num_reads_per_iter  in  LOG_MAX_READS_PER_ITER  beats per iteration.
- zero_skip  in  1  1 = zeros are excluded from the unique list.
- data_in  in  INPUT_WIDTH  element i at [i*DATA_WIDTH +: DATA_WIDTH].
- valid_in  in  1  write strobe.
- avail_out  out  1  upstream may write.
- data_out  out  OUTPUT_WIDTH  packed, LSB first: uniq values, idx map (IDX_W per element), zero mask, unique count.
- valid_out  out  1  data_out valid this cycle.
- avail_in  in  1  downstream can accept.
- done  out  1  one-cycle pulse after the last beat of the last iteration is emitted.
- unique_total  out  STAT_WIDTH  saturating sum of UNIQUE_CNT over emitted beats.

Behaviour:
- Reset values (rst=1 at clock edge): FIFO empty; enabled=0; all counters=0; valid_out=0; data_out=0; done=0; unique_total=0; avail_out=1 from the next cycle.
- Input buffer:
  - A write occurs when valid_in=1; writes while full are dropped (protocol violation).
  - avail_out = ~full & ~almost_full, where almost_full means one slot left. Upstream may therefore write one beat after avail_out falls.
  - The buffer is first-word-fall-through: a beat written in cycle t is visible at the head in t+1.
- Fire condition: fire = enabled & ~empty & (avail_in | ~valid_out_r).
  - On fire: the head is popped, compaction is computed combinationally, and the result is registered into data_out with valid_out=1.
  - Without fire: valid_out clears when avail_in=1; otherwise data_out and valid_out hold unchanged.
  - Latency from write to valid_out is 2 cycles. Throughput is 1 beat/cycle.
- Compaction for element j, with z_j = (e_j==0):
  - first_j = no k<j with e_k==e_j, and not (zero_skip & z_j).
  - pos_j = number of first_k for k<j.
  - uniq[pos_j] = e_j for each first_j element. Unused uniq slots are 0.
  - idx_j = pos of the first occurrence of e_j. In zero_skip mode, idx_j = 0 when z_j.
  - zero_mask_j = z_j in both modes.
  - UNIQUE_CNT = number of first_j, ranging 0..GROUP_SIZE.
- Iteration FSM:
  - States IDLE, RUN, FIN. Counters r (reads left) and n (iterations left).
  - IDLE→RUN on configure with num_iters≠0 and num_reads_per_iter≠0. Latches n, r, a copy of r, and zero_skip; clears unique_total.
  - IDLE→FIN on configure with either value = 0. No beats are consumed.
  - RUN, on each fire:
    - if r==1 and n==1 → FIN;
    - else if r==1 → n−1, r reloaded from the copy;
    - else r−1.
  - FIN: done=1 for one cycle, gated on valid_out having drained (valid_out=0 or avail_in=1 in the same cycle). Then → IDLE.
  - enabled = (state==RUN).
- configure during RUN or FIN aborts the current sequence and restarts from the new values. It does not flush the FIFO or output register. configure has priority over a same-cycle fire decrement; the fire still pops.
- unique_total adds UNIQUE_CNT on each fire and saturates at all-ones.
- rst mid-operation: everything returns to the reset values on the next edge, including a pending output. No done is generated.

Decomposition:
- Shared package/header (RTLinf.vh): IDX_W and CNT_W derivation macros, packed-field offset macros for data_out, and FSM state encodings.
- One natural sub-module: the existing parametrised FIFO, instantiated with NUM_SLOTS=FIFO_DEPTH and LOG_NUM_SLOTS=$clog2(FIFO_DEPTH).
- The compaction network stays inline, in generate loops plus one always @(*).

Test Plan:
- GS=4, DW=8, zero_skip=0, configure iters=1/reads=1, write {3,2,3,3} (e0..e3) → after 2 cycles valid_out=1, uniq={3,2,0,0}, idx={0,1,0,0}, zero_mask=0000, cnt=2; done next cycle; unique_total=2.
- Write {0,5,0,5}, once with zero_skip=0 and once with zero_skip=1:
  - zero_skip=0 → uniq={0,5,0,0}, idx={0,1,0,1}, cnt=2, zero_mask=0101;
  - zero_skip=1 → uniq={5,0,0,0}, idx={0,0,0,0}, cnt=1, zero_mask=0101.
- {1,2,3,4} → cnt=4, idx={0,1,2,3}. {0,0,0,0} with zero_skip=1 → cnt=0, uniq all 0.
- iters=2, reads=3, 8 beats written, avail_in toggled 1/0 every cycle:
  - exactly 6 outputs, in order;
  - data_out stable while avail_in=0;
  - done pulses once;
  - 2 beats remain buffered; avail_out never allows overflow.
- configure with reads=0 → done pulses 1 cycle later with no valid_out; configure mid-RUN → counters restart and unique_total clears.
- rst=1 asserted while valid_out=1 and the FIFO holds 3 beats → next cycle valid_out=0, done=0, unique_total=0, and a post-reset configure emits only newly written beats.
